// File: rtl/light_mode_pkg.sv
// Shared encodings for the light mode controller: lamp modes and press-FSM states.
package light_mode_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_ON   = 2'd1,
        MODE_SLOW = 2'd2,
        MODE_FAST = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_HELD  = 2'd2
    } press_st_t;

    // Short-press rotation; the 2-bit encoding wraps FAST back to OFF.
    function automatic mode_t next_mode(input mode_t m);
        logic [1:0] nxt;
        nxt = m + 2'd1;
        return mode_t'(nxt);
    endfunction

endpackage

// File: rtl/light_mode_ctrl_if.sv
// Button/lamp bus of the light mode controller; master drives the button, slave drives the lamp side.
interface light_mode_ctrl_if;
    import light_mode_pkg::*;

    logic  button;
    logic  light;
    mode_t mode;
    logic  short_evt;
    logic  long_evt;

    modport master (output button, input light, mode, short_evt, long_evt);
    modport slave  (input button, output light, mode, short_evt, long_evt);

endinterface

// File: rtl/key_debounce.sv
// Two-flop synchronizer followed by a stability-window debouncer.
module key_debounce #(
    parameter int DEB_CYC = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_db
);

    localparam int CW = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // cnt counts consecutive cycles where the synchronized key disagrees with key_db.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '0;
            cnt    <= '0;
            key_db <= 1'b0;
        end else begin
            sync <= {sync[0], key_in};
            if (sync[1] == key_db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                key_db <= sync[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/light_mode_ctrl.sv
// Single-button lamp controller: short press rotates the mode, long press turns the lamp off.
module light_mode_ctrl
    import light_mode_pkg::*;
#(
    parameter int DEB_CYC    = 20,
    parameter int LONG_CYC   = 100,
    parameter int BLINK_HALF = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    light_mode_ctrl_if.slave   bus
);

    localparam int PW = $clog2(LONG_CYC);
    localparam int BW = $clog2(BLINK_HALF);
    localparam logic [PW-1:0] PRESS_LAST = PW'(LONG_CYC - 2);
    localparam logic [BW-1:0] SLOW_LAST  = BW'(BLINK_HALF - 1);
    localparam logic [BW-1:0] FAST_LAST  = BW'(BLINK_HALF / 4 - 1);

    logic            btn_db;
    press_st_t       st;
    logic [PW-1:0]   press_cnt;
    logic            short_q;
    logic            long_q;
    mode_t           mode_q;
    logic            light_q;
    logic [BW-1:0]   blink_cnt;
    logic [BW-1:0]   half_last;

    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_in (bus.button),
        .key_db (btn_db)
    );

    // Long press fires on the edge press_cnt reaches LONG_CYC-1, i.e. the
    // LONG_CYC-th debounced-high cycle; a release before that is a short press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= ST_IDLE;
            press_cnt <= '0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            short_q <= 1'b0;
            long_q  <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (btn_db) begin
                        st        <= ST_PRESS;
                        press_cnt <= '0;
                    end
                end
                ST_PRESS: begin
                    if (!btn_db) begin
                        st      <= ST_IDLE;
                        short_q <= 1'b1;
                    end else begin
                        press_cnt <= press_cnt + PW'(1);
                        if (press_cnt == PRESS_LAST) begin
                            long_q <= 1'b1;
                            st     <= ST_HELD;
                        end
                    end
                end
                ST_HELD: begin
                    if (!btn_db) st <= ST_IDLE;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    assign half_last = (mode_q == MODE_SLOW) ? SLOW_LAST : FAST_LAST;

    // Every mode entry restarts the blink phase with the lamp lit (except OFF).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= MODE_OFF;
            light_q   <= 1'b0;
            blink_cnt <= '0;
        end else if (long_q) begin
            mode_q    <= MODE_OFF;
            light_q   <= 1'b0;
            blink_cnt <= '0;
        end else if (short_q) begin
            mode_q    <= next_mode(mode_q);
            light_q   <= (next_mode(mode_q) != MODE_OFF);
            blink_cnt <= '0;
        end else begin
            case (mode_q)
                MODE_OFF: light_q <= 1'b0;
                MODE_ON:  light_q <= 1'b1;
                default: begin
                    if (blink_cnt == half_last) begin
                        light_q   <= ~light_q;
                        blink_cnt <= '0;
                    end else begin
                        blink_cnt <= blink_cnt + BW'(1);
                    end
                end
            endcase
        end
    end

    assign bus.light     = light_q;
    assign bus.mode      = mode_q;
    assign bus.short_evt = short_q;
    assign bus.long_evt  = long_q;

endmodule

// File: doc/light_mode_ctrl.md
LIGHT_MODE_CTRL -- requirements
Module: light_mode_ctrl

Interface
REQ-001 Parameter DEB_CYC, default 20, debounce stability window in clk cycles (>=2).
REQ-002 Parameter LONG_CYC, default 100, press duration in debounced-high cycles that classifies a long press (> DEB_CYC).
REQ-003 Parameter BLINK_HALF, default 64, slow-blink half period in cycles; SHALL be a multiple of 4 and >=4.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 button  input  1  raw asynchronous push-button, high = pressed.
REQ-007 light  output  1  registered lamp drive.
REQ-008 mode  output  2  registered mode: 0 OFF, 1 ON, 2 BLINK_SLOW, 3 BLINK_FAST.
REQ-009 short_evt  output  1  one-cycle pulse on a short press.
REQ-010 long_evt  output  1  one-cycle pulse on a long press.

Function
REQ-011 button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Debounce: btn_db SHALL take the synchronized value only after it differs from btn_db for DEB_CYC consecutive cycles; any cycle of equality SHALL clear the counter.
REQ-013 Press FSM states IDLE, PRESS, HELD; IDLE->PRESS on btn_db rise, with the press counter cleared.
REQ-014 In PRESS, the counter increments each cycle; on the cycle it reaches LONG_CYC-1, long_evt SHALL pulse and the FSM SHALL enter HELD.
REQ-015 PRESS->IDLE on btn_db fall, with short_evt pulsing that same cycle.
REQ-016 HELD->IDLE on btn_db fall, with no event; holding longer SHALL NOT repeat long_evt.
REQ-017 short_evt and long_evt SHALL never be high in the same cycle.
REQ-018 Mode sequence on short_evt: OFF->ON->BLINK_SLOW->BLINK_FAST->OFF (wrap); mode SHALL update on the edge after the pulse.
REQ-019 Mode on long_evt: OFF from any mode, including OFF.
REQ-020 Light output by mode: OFF gives 0; ON gives 1.
REQ-021 Light output in blink modes: toggles every BLINK_HALF cycles (slow) or every BLINK_HALF/4 cycles (fast).
REQ-022 On entry to any mode, the blink counter SHALL clear; on entry to a blink mode, light SHALL be 1 in the same cycle mode changes.
REQ-023 Blink counter SHALL wrap at its half period with no drift; no output SHALL glitch, since all are registered.
REQ-024 Latency: a clean press edge reaches btn_db in 2+DEB_CYC cycles (+/-1); mode changes 1 cycle after the event pulse.

Reset
REQ-025 Asserting rst_n low SHALL immediately force these values, even mid-press or mid-blink: light=0, mode=OFF, short_evt=0, long_evt=0, FSM=IDLE, btn_db=0, synchronizer and all counters 0.
REQ-026 A button held through reset release SHALL be treated as a new press once debounced.

Structure
REQ-027 Package light_mode_pkg SHALL hold the mode encoding constants (OFF/ON/BLINK_SLOW/BLINK_FAST) and the press-FSM state encoding.
REQ-028 The synchronizer and debounce SHALL be sub-module key_debounce (ports clk, rst_n, key_in, key_db); the FSM, mode and blink logic SHALL stay in the top.

Verification (DEB_CYC=4, LONG_CYC=20, BLINK_HALF=8)
REQ-029 Short press case: press 10 cycles, then release -> one short_evt; mode 0->1; light=1.
REQ-030 Bounce case: 3-cycle glitches on button while idle -> btn_db stays 0; no events; mode unchanged.
REQ-031 Mode cycling case: four short presses from OFF -> mode 1,2,3,0; in mode 2 light toggles every 8 cycles; in mode 3 every 2 cycles, starting at 1.
REQ-032 Long press case: hold 50 cycles in mode 2 -> exactly one long_evt about 20 cycles after btn_db rise; mode=0; light=0; no short_evt on release.
REQ-033 Reset mid-blink case: rst_n low in mode 3 with button held -> all outputs 0 at once; after release with button still held, a press is detected after debounce.
REQ-034 Boundary case: press lasting exactly 19 debounced cycles -> short_evt; exactly 20 -> long_evt.
